// File: rtl/multicycle_core_if.sv
// Instruction and data memory req/ack bundle for multicycle_core.
// master = core side, slave = memory side.
interface multicycle_core_if #(
    parameter int DW = 32,
    parameter int AW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle core: FETCH/DECODE/EXEC/MEM/WB/HALT over req/ack memories.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap illegal opcodes (err + HALT).
module multicycle_core #(
    parameter int DW = 32,
    parameter int NREG = 32,
    parameter int AW = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_core_if.master bus,
    output logic [AW-1:0]     pc,
    output logic              retire,
    output logic              halted,
    output logic              err
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] rf_q [NREG];

    logic          rf_we;
    logic [RW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          imem_req_c;
    logic          dmem_req_c;
    logic          dmem_we_c;

    logic [5:0]    op;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    logic          is_r, is_i, is_lw, is_sw;
    logic          is_beq, is_bne, is_jmp, is_halt;
    logic [DW-1:0] imm_s, opb, alu_res, addr_sum;
    logic [AW-1:0] br_tgt, jmp_tgt;
    logic          br_taken;

    assign op     = ir_q[31:26];
    assign rs_idx = ir_q[21 +: RW];
    assign rt_idx = ir_q[16 +: RW];
    assign rd_idx = ir_q[11 +: RW];

    assign is_r    = (op[5:4] == 2'b00);
    assign is_i    = (op[5:4] == 2'b01);
    assign is_lw   = (op == 6'b100000);
    assign is_sw   = (op == 6'b100001);
    assign is_beq  = (op == 6'b110000);
    assign is_bne  = (op == 6'b110001);
    assign is_jmp  = (op == 6'b110010);
    assign is_halt = (op == 6'b111111);

    assign imm_s    = DW'($signed(ir_q[15:0]));
    assign opb      = is_r ? b_q : imm_s;
    assign addr_sum = a_q + imm_s;
    // pc_q already holds pc+1 by the time EXEC runs
    assign br_tgt   = pc_q + imm_s[AW-1:0];
    assign jmp_tgt  = AW'(ir_q[15:0]);
    assign br_taken = is_beq ? (a_q == b_q) : (a_q != b_q);

    always_comb begin
        alu_res = a_q;
        case (op[3:0])
            4'd0:    alu_res = a_q + opb;
            4'd1:    alu_res = a_q - opb;
            4'd2:    alu_res = a_q & opb;
            4'd3:    alu_res = a_q | opb;
            4'd4:    alu_res = a_q ^ opb;
            4'd5:    alu_res = DW'($signed(a_q) < $signed(opb));
            4'd6:    alu_res = a_q << opb[4:0];
            4'd7:    alu_res = a_q >> opb[4:0];
            default: alu_res = a_q;
        endcase
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        err_d      = err_q;
`endif
        rf_we      = 1'b0;
        rf_wa      = is_r ? rd_idx : rt_idx;
        rf_wd      = is_lw ? mdr_q : alu_q;
        retire     = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs_idx];
                b_d     = rf_q[rt_idx];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_r, is_i: begin
                        alu_d   = alu_res;
                        state_d = S_WB;
                    end
                    is_lw, is_sw: begin
                        alu_d   = addr_sum;
                        state_d = S_MEM;
                    end
                    is_beq, is_bne: begin
                        if (br_taken) pc_d = br_tgt;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    is_jmp: begin
                        pc_d    = jmp_tgt;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    is_halt: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        err_d   = 1'b1;
                        state_d = S_HALT;
`else
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_sw;
                if (bus.dmem_ack) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = bus.dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // r0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_wa != '0)) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Requests are masked by reset so they fall the moment rst_n drops
    assign bus.imem_req   = imem_req_c & rst_n;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_c & rst_n;
    assign bus.dmem_we    = dmem_we_c & rst_n;
    assign bus.dmem_addr  = alu_q[AW-1:0];
    assign bus.dmem_wdata = b_q;

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);
endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multicycle processor core: datapath plus control FSM in one block.
- Fetches, decodes and executes one instruction over several clock cycles.
- Talks to external instruction and data memories through req/ack handshakes that tolerate wait states.
- Generalises the original fixed 32-bit datapath in data width, register count and address width, and adds a sequencer, a handshaked memory interface and a halt state.

Parameters:
- DW, 32, datapath/register width in bits; legal range 16..32.
- NREG, 32, number of registers; power of 2, 2..32; r0 reads as 0 and ignores writes.
- AW, 16, PC and memory address width in bits (word addressed).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  AW  data address.
- dmem_wdata  out  DW  store data.
- dmem_ack  in  1  access complete; dmem_rdata valid for loads.
- dmem_rdata  in  DW  load data.
- pc  out  AW  current PC.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- halted  out  1  core is in HALT.
- err  out  1  illegal opcode trapped (sticky).

Behaviour:
- Instruction format: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm. Register indices use the low log2(NREG) bits.
- Immediate: imm is sign-extended or truncated to DW. Memory and branch addresses use the low AW bits of the result.
- op[5:4]=00, R-type: rd = rs ALU rt.
- op[5:4]=01, I-type: rt = rs ALU sext(imm).
- ALU functions, selected by op[3:0]:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed compare; result 1 or 0).
  - 6 SLL by b[4:0]; 7 SRL by b[4:0].
  - 8..15 pass a.
- Memory, branch and control opcodes:
  - 100000 LW: rt = mem[rs+sext(imm)].
  - 100001 SW: mem[rs+sext(imm)] = rt.
  - 110000 BEQ, 110001 BNE: taken target = pc+1+sext(imm); not taken = pc+1.
  - 110010 JMP: pc = zero-extended imm.
  - 111111 HALT.
  - All other opcodes are illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - Stays in FETCH until imem_ack=1 is sampled (ack may arrive in the same cycle as req).
  - On ack: IR <= imem_rdata, pc <= pc+1, go to DECODE.
- DECODE: A <= reg[rs], B <= reg[rt], go to EXEC.
- EXEC:
  - ALU ops: ALUOut <= result, go to WB.
  - LW/SW: ALUOut <= address, go to MEM.
  - BEQ/BNE: pc updated if the branch is taken; retire; go to FETCH.
  - JMP: pc <= target; retire; go to FETCH.
  - HALT: retire; go to HALT.
- MEM:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata (= B) are held stable until dmem_ack.
  - On ack, LW: MDR <= dmem_rdata, go to WB.
  - On ack, SW: retire, go to FETCH.
- WB: register write (rd for R-type, rt for I-type/LW); retire; go to FETCH.
- HALT: absorbing state; halted=1; no requests are issued; only reset exits.
- Latency with zero-wait memory (ack in the same cycle):
  - 4 cycles: ALU ops, SW.
  - 5 cycles: LW.
  - 3 cycles: BEQ, BNE, JMP, HALT.
  - Each wait cycle adds exactly 1.
- A write to r0 is discarded. The register file is read in DECODE only, so no forwarding is required.
- Reset (async, including mid-transaction):
  - state=FETCH, pc=RESET_PC.
  - All registers, IR, A, B, ALUOut and MDR = 0.
  - imem_req=dmem_req=dmem_we=0, retire=0, halted=0, err=0.
  - Requests drop immediately; an ack arriving after reset is ignored.
- PC arithmetic wraps modulo 2^AW. pc+1 from all-ones yields 0.
- Req is never dropped before ack. Ack while req=0 is ignored.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXEC sets err=1 (sticky until reset), does not retire, and enters HALT.
- Undefined: an illegal opcode executes as a NOP (retire in EXEC, 3 cycles); err is tied to 0.

Test Plan:
- R-type, zero-wait memory:
  - Stimulus: reg r1=5, r2=7, execute ADD r3,r1,r2 (op 000000).
  - Required: r3=12; retire 4 cycles after the fetch; pc advances by 1.
- Load/store with wait states, DW=32:
  - Stimulus: SW r3 to [r0+0x10], then LW r4 from [r0+0x10]; dmem_ack delayed 2 cycles.
  - Required: dmem_addr=0x10 and dmem_wdata=12 held stable while waiting; r4=12; LW takes 7 cycles.
- Branches:
  - Stimulus: BEQ r1,r1,imm=-2 at pc=8.
  - Required: pc=7.
  - Stimulus: BNE r1,r1 at pc=8.
  - Required: pc=9; each branch takes 3 cycles.
- JMP and wrap:
  - Stimulus: JMP 0xFFFF with AW=16, then one ALU instruction.
  - Required: next fetch at 0xFFFF; following fetch at 0x0000.
- Halt and reset mid-operation:
  - Stimulus: HALT instruction.
  - Required: halted=1; no requests issued for 20 cycles.
  - Stimulus: assert rst_n=0 while dmem_req=1.
  - Required: dmem_req=0 immediately; pc=RESET_PC; r0 write attempts leave r0 reading 0.
- Illegal opcode 101111:
  - With MULTICYCLE_ILLEGAL_TRAP_EN defined: err=1, halted=1, retire stays 0.
  - Without it: retire pulses and pc advances by 1.
